// File: rtl/load_instruction.sv
// DS-form load/store datapath: register file, ALU_64 address unit and
// a 128-word data memory, with register write-back of the loaded word.

module ALU_64 #(
  parameter int N = 64
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [3:0]   i_op,
  output logic [N-1:0] o_result,
  output logic         o_cout,
  output logic         o_overflow,
  output logic         o_slt,
  output logic         o_zero
);

  logic         w_op_and;
  logic         w_op_or;
  logic         w_op_add;
  logic         w_op_sub;
  logic         w_op_slt;
  logic         w_op_nor;
  logic [N-1:0] w_b_eff;
  logic [N:0]   w_sum;

  assign w_op_and = (i_op == 4'b0000);
  assign w_op_or  = (i_op == 4'b0001);
  assign w_op_add = (i_op == 4'b0010);
  assign w_op_sub = (i_op == 4'b0110);
  assign w_op_slt = (i_op == 4'b0111);
  assign w_op_nor = (i_op == 4'b1100);

  // Subtract reuses the adder through two's complement of b
  assign w_b_eff = w_op_sub ? ~i_b : i_b;
  assign w_sum   = {1'b0, i_a}
                 + {1'b0, w_b_eff}
                 + {{N{1'b0}}, w_op_sub};

  assign o_cout     = w_sum[N];
  assign o_slt      = $signed(i_a) < $signed(i_b);
  assign o_overflow = (w_op_add | w_op_sub)
                    & (i_a[N-1] == w_b_eff[N-1])
                    & (w_sum[N-1] != i_a[N-1]);
  assign o_zero     = (o_result == '0);

  always_comb begin
    o_result = '0;
    unique case (1'b1)
      w_op_and: o_result = i_a & i_b;
      w_op_or:  o_result = i_a | i_b;
      w_op_add: o_result = w_sum[N-1:0];
      w_op_sub: o_result = w_sum[N-1:0];
      w_op_slt: o_result = {{(N-1){1'b0}}, o_slt};
      w_op_nor: o_result = ~(i_a | i_b);
      default:  o_result = '0;
    endcase
  end

endmodule

module reg_file #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   i_ra1,
  input  logic [4:0]   i_ra2,
  input  logic [4:0]   i_wa,
  input  logic [N-1:0] i_wd,
  input  logic         i_we,
  output logic [N-1:0] o_rd1,
  output logic [N-1:0] o_rd2
);

  logic [N-1:0] r_regs [32];

  assign o_rd1 = r_regs[i_ra1];
  assign o_rd2 = r_regs[i_ra2];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_wa] <= i_wd;
    end
  end

endmodule

module data_memory #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic [6:0]   i_addr,
  input  logic [N-1:0] i_wd,
  input  logic         i_we,
  input  logic         i_re,
  output logic [N-1:0] o_rd
);

  localparam logic [N-1:0] C8 = N'(8);

  // Power-up image; reset deliberately leaves memory alone
  logic [N-1:0] r_mem [128] = '{
    1: C8, 2: C8, 3: C8, 4: C8, 5: C8,
    6: C8, 7: C8, 8: C8, 9: C8, 10: C8,
    default: '0
  };

  assign o_rd = i_re ? r_mem[i_addr] : '0;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wd;
    end
  end

endmodule

module load_instruction #(
  parameter int N = 64
) (
  input  logic [31:0] instruction,
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ALU_OP,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite
);

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [4:0]  ra;
    logic [13:0] ds;
    logic [1:0]  xo;
  } ds_form_t;

  ds_form_t     w_dec;
  logic [N-1:0] w_ra_val;
  logic [N-1:0] w_rt_val;
  logic [N-1:0] w_imm;
  logic [N-1:0] w_result;
  logic [N-1:0] w_rdata;
  logic         w_cout;
  logic         w_ovf;
  logic         w_slt;
  logic         w_zero;
  logic         w_unused;

  assign w_dec = instruction;
  // DS field is used as a word offset, so no left shift
  assign w_imm = {{(N-14){w_dec.ds[13]}}, w_dec.ds};

  reg_file #(.N(N)) RF (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (w_dec.ra),
    .i_ra2 (w_dec.rt),
    .i_wa  (w_dec.rt),
    .i_wd  (w_rdata),
    .i_we  (RegWrite),
    .o_rd1 (w_ra_val),
    .o_rd2 (w_rt_val)
  );

  ALU_64 #(.N(N)) ALU (
    .i_a        (w_ra_val),
    .i_b        (w_imm),
    .i_op       (ALU_OP),
    .o_result   (w_result),
    .o_cout     (w_cout),
    .o_overflow (w_ovf),
    .o_slt      (w_slt),
    .o_zero     (w_zero)
  );

  data_memory #(.N(N)) DataMemory (
    .clk    (clk),
    .i_addr (w_result[6:0]),
    .i_wd   (w_rt_val),
    .i_we   (MemWrite),
    .i_re   (MemRead),
    .o_rd   (w_rdata)
  );

  assign w_unused = ^{w_dec.opcode, w_dec.xo,
                      w_result[N-1:7],
                      w_cout, w_ovf, w_slt, w_zero};

endmodule

// File: tb/tb_load_instruction.sv
// Directed bench for load_instruction: hand-computed register and
// memory contents checked hierarchically after each clock edge.

module tb_load_instruction;

  logic [31:0] instruction;
  logic        clk;
  logic        rst;
  logic [3:0]  ALU_OP;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;

  int n_vec;
  int n_fail;

  load_instruction #(.N(64)) dut (
    .instruction (instruction),
    .clk         (clk),
    .rst         (rst),
    .ALU_OP      (ALU_OP),
    .RegWrite    (RegWrite),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] rt,
                                     input logic [4:0] ra,
                                     input logic [13:0] imm);
    return {6'b111010, rt, ra, imm, 2'b00};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [3:0] op,
                       input logic rw, input logic mr, input logic mw);
    instruction = ins;
    ALU_OP      = op;
    RegWrite    = rw;
    MemRead     = mr;
    MemWrite    = mw;
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive(32'h0, 4'b0010, 1'b1, 1'b0, 1'b0);

    // reset for two edges
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("reset_R%0d", i), dut.RF.r_regs[i], 64'd0);
    end
    chk("init_mem0", dut.DataMemory.r_mem[0], 64'd0);
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("init_mem%0d", i), dut.DataMemory.r_mem[i], 64'd8);
    end
    chk("init_mem11", dut.DataMemory.r_mem[11], 64'd0);

    // ld R1,4(R2)
    drive(32'hE8220010, 4'b0010, 1'b1, 1'b1, 1'b0);
    tick();
    chk("ld_R1", dut.RF.r_regs[1], 64'd8);
    chk("ld_R2_kept", dut.RF.r_regs[2], 64'd0);

    // std R1,20(R0)
    drive(32'hE8200050, 4'b0010, 1'b0, 1'b0, 1'b1);
    tick();
    chk("st_mem20", dut.DataMemory.r_mem[20], 64'd8);
    chk("st_R1_kept", dut.RF.r_regs[1], 64'd8);

    // ld R5,20(R0)
    drive(32'hE8A00050, 4'b0010, 1'b1, 1'b1, 1'b0);
    tick();
    chk("ld_R5", dut.RF.r_regs[5], 64'd8);

    // MemRead off: writes zero
    drive(32'hE8A00050, 4'b0010, 1'b1, 1'b0, 1'b0);
    tick();
    chk("noread_R5", dut.RF.r_regs[5], 64'd0);

    // RegWrite off: no change
    drive(32'hE8A00050, 4'b0010, 1'b0, 1'b1, 1'b0);
    tick();
    chk("nowrite_R5", dut.RF.r_regs[5], 64'd0);
    chk("nowrite_R1", dut.RF.r_regs[1], 64'd8);

    // address wrap: 130 -> word 2
    dut.RF.r_regs[3] = 64'd130;
    drive(mk(5'd6, 5'd3, 14'd0), 4'b0010, 1'b1, 1'b1, 1'b0);
    tick();
    chk("wrap_R6", dut.RF.r_regs[6], 64'd8);

    // immediate -1 with base 5 -> word 4
    dut.RF.r_regs[7] = 64'd5;
    drive(mk(5'd8, 5'd7, 14'h3FFF), 4'b0010, 1'b1, 1'b1, 1'b0);
    tick();
    chk("sign_R8", dut.RF.r_regs[8], 64'd8);

    // RT == RA: address uses pre-edge value 3
    dut.RF.r_regs[9] = 64'd3;
    drive(mk(5'd9, 5'd9, 14'd0), 4'b0010, 1'b1, 1'b1, 1'b0);
    tick();
    chk("rteqra_R9", dut.RF.r_regs[9], 64'd8);

    // read and write same word: old value returned
    drive(mk(5'd1, 5'd0, 14'd40), 4'b0010, 1'b1, 1'b1, 1'b1);
    tick();
    chk("rw_R1_old", dut.RF.r_regs[1], 64'd0);
    chk("rw_mem40", dut.DataMemory.r_mem[40], 64'd8);

    // reset wins over RegWrite; memory write still lands
    rst = 1'b1;
    drive(mk(5'd6, 5'd0, 14'd30), 4'b0010, 1'b1, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    chk("rstpri_R6", dut.RF.r_regs[6], 64'd0);
    chk("rstpri_R8", dut.RF.r_regs[8], 64'd0);
    chk("rstpri_mem30", dut.DataMemory.r_mem[30], 64'd8);
    chk("rstpri_mem4", dut.DataMemory.r_mem[4], 64'd8);

    // distinct memory image so each ALU result is visible
    for (int k = 11; k < 128; k++) begin
      dut.DataMemory.r_mem[k] = 64'(1000 + k);
    end
    dut.RF.r_regs[9]  = 64'd90;
    dut.RF.r_regs[10] = 64'hFFFF_FFFF_FFFF_FFFD;
    dut.RF.r_regs[18] = 64'd55;

    drive(mk(5'd12, 5'd9, 14'd60), 4'b0000, 1'b1, 1'b1, 1'b0);
    tick();
    chk("alu_and", dut.RF.r_regs[12], 64'd1024);

    drive(mk(5'd13, 5'd9, 14'd60), 4'b0001, 1'b1, 1'b1, 1'b0);
    tick();
    chk("alu_or", dut.RF.r_regs[13], 64'd1126);

    drive(mk(5'd14, 5'd9, 14'd60), 4'b0010, 1'b1, 1'b1, 1'b0);
    tick();
    chk("alu_add", dut.RF.r_regs[14], 64'd1022);

    drive(mk(5'd15, 5'd9, 14'd60), 4'b0110, 1'b1, 1'b1, 1'b0);
    tick();
    chk("alu_sub", dut.RF.r_regs[15], 64'd1030);

    drive(mk(5'd19, 5'd9, 14'd100), 4'b0110, 1'b1, 1'b1, 1'b0);
    tick();
    chk("alu_sub_neg", dut.RF.r_regs[19], 64'd1118);

    drive(mk(5'd16, 5'd10, 14'd60), 4'b0111, 1'b1, 1'b1, 1'b0);
    tick();
    chk("alu_slt", dut.RF.r_regs[16], 64'd8);

    drive(mk(5'd17, 5'd9, 14'd60), 4'b1100, 1'b1, 1'b1, 1'b0);
    tick();
    chk("alu_nor", dut.RF.r_regs[17], 64'd8);

    drive(mk(5'd18, 5'd9, 14'd60), 4'b0011, 1'b1, 1'b1, 1'b0);
    tick();
    chk("alu_unlisted", dut.RF.r_regs[18], 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
